pixel_stream_proc: RTL and testbench

- Parametrised, synthesisable pixel-stream processing engine for the PNG test flow: the tester streams a decoded image in raster order and collects the processed stream for writing back to PNG.
- Generalises the fixed-image flow in four ways: run-time frame geometry, 1 to 4 channels, selectable point operation, and frame-geometry checking with a done/error handshake that the tester waits on.

---
 rtl/pixel_proc_pkg.sv | 24 ++
 rtl/pixel_op_pipe.sv | 130 +++++++++++++
 rtl/pixel_stream_proc.sv | 137 +++++++++++++
 tb/tb_pixel_stream_proc.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_proc_pkg.sv
// rtl/pixel_proc_pkg.sv - shared types and luma constants for pixel_stream_proc
package pixel_proc_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    INVERT = 2'd1,
    GRAY   = 2'd2,
    THRESH = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int LUMA_R     = 77;
  localparam int LUMA_G     = 150;
  localparam int LUMA_B     = 29;
  localparam int LUMA_SHIFT = 8;

endpackage

// File: rtl/pixel_op_pipe.sv
// rtl/pixel_op_pipe.sv - 2-stage elastic point-operation datapath
// Stage 1 holds the pixel and luma products, stage 2 the selected result.
module pixel_op_pipe
  import pixel_proc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     mode,
  input  logic [DATA_WIDTH-1:0]          thresh,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic                           in_sof,
  input  logic                           in_eol,
  input  logic                           in_eof,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_sof,
  output logic                           out_eol,
  output logic                           out_eof,
  output logic                           empty_next
);

  localparam int PW  = CHANNELS * DATA_WIDTH;
  localparam int PRW = DATA_WIDTH + 8;
  localparam int ACW = DATA_WIDTH + 10;

  logic                  s1_valid;
  logic [PW-1:0]         s1_data;
  logic                  s1_sof, s1_eol, s1_eof;
  logic                  s2_ready;
  logic [DATA_WIDTH-1:0] luma;
  logic                  luma_hi;
  logic [PW-1:0]         op_data;

  assign s2_ready   = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_ready;
  // True when nothing new enters and whatever is left leaves this cycle.
  assign empty_next = !s1_valid && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sof   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_sof  <= in_sof;
        s1_eol  <= in_eol;
        s1_eof  <= in_eof;
      end
    end
  end

  generate
    if (CHANNELS >= 3) begin : g_luma
      logic [PRW-1:0] prod_r, prod_g, prod_b;
      logic [ACW-1:0] acc;
      logic           unused_acc_bits;

      always_ff @(posedge clk) begin
        if (reset) begin
          prod_r <= '0;
          prod_g <= '0;
          prod_b <= '0;
        end else if (in_ready && in_valid) begin
          prod_r <= PRW'(LUMA_R) * PRW'(in_data[0*DATA_WIDTH +: DATA_WIDTH]);
          prod_g <= PRW'(LUMA_G) * PRW'(in_data[1*DATA_WIDTH +: DATA_WIDTH]);
          prod_b <= PRW'(LUMA_B) * PRW'(in_data[2*DATA_WIDTH +: DATA_WIDTH]);
        end
      end

      // Coefficients sum to 256, so the shifted sum never exceeds full scale.
      assign acc  = ACW'(prod_r) + ACW'(prod_g) + ACW'(prod_b);
      assign luma = acc[LUMA_SHIFT +: DATA_WIDTH];
      assign unused_acc_bits = ^{acc[ACW-1:LUMA_SHIFT+DATA_WIDTH], acc[LUMA_SHIFT-1:0]};
    end else begin : g_no_luma
      assign luma = s1_data[0 +: DATA_WIDTH];
    end
  endgenerate

  assign luma_hi = (luma >= thresh);

  always_comb begin
    op_data = s1_data;
    case (mode_e'(mode))
      INVERT: op_data = ~s1_data;
      GRAY: begin
        if (CHANNELS >= 3) begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (c < 3) op_data[c*DATA_WIDTH +: DATA_WIDTH] = luma;
          end
        end
      end
      THRESH: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (c < 3 || CHANNELS < 3) op_data[c*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{luma_hi}};
        end
      end
      default: op_data = s1_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= op_data;
        out_sof  <= s1_sof;
        out_eol  <= s1_eol;
        out_eof  <= s1_eof;
      end
    end
  end

endmodule

// File: rtl/pixel_stream_proc.sv
// rtl/pixel_stream_proc.sv - frame FSM, raster counters and geometry checking
// around the pixel_op_pipe datapath.
module pixel_stream_proc
  import pixel_proc_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  CHANNELS   = 3,
  parameter int  MAX_WIDTH  = 1024,
  parameter int  MAX_HEIGHT = 1024,
  localparam int XW         = $clog2(MAX_WIDTH + 1),
  localparam int YW         = $clog2(MAX_HEIGHT + 1),
  localparam int PW         = CHANNELS * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XW-1:0]         cfg_width,
  input  logic [YW-1:0]         cfg_height,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_thresh,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err_size,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PW-1:0]         s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PW-1:0]         m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);

  state_e                state;
  logic [XW-1:0]         width_q, x, bx;
  logic [YW-1:0]         height_q, y, by;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] thresh_q;
  logic                  pipe_ready, pipe_empty_next;
  logic                  push, sof_bad, eol_bad, last_x, last_y, bad_geom;

  assign s_ready = ((state == WAIT_SOF) || (state == RUN)) && pipe_ready;
  assign push    = s_valid && s_ready && ((state == RUN) || s_sof);

  // A misplaced sof restarts the raster with the current beat as (0,0).
  assign sof_bad = (state == RUN) && s_sof && ((x != '0) || (y != '0));
  assign bx      = sof_bad ? '0 : x;
  assign by      = sof_bad ? '0 : y;
  assign last_x  = (bx == width_q - XW'(1));
  assign last_y  = (by == height_q - YW'(1));
  assign eol_bad = (s_eol != last_x);

  assign bad_geom = (cfg_width == '0) || (cfg_width > XW'(MAX_WIDTH)) ||
                    (cfg_height == '0) || (cfg_height > YW'(MAX_HEIGHT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_size <= 1'b0;
      width_q  <= '0;
      height_q <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
      x        <= '0;
      y        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
            mode_q   <= cfg_mode;
            thresh_q <= cfg_thresh;
            busy     <= 1'b1;
            err_size <= bad_geom;
            x        <= '0;
            y        <= '0;
            // A rejected frame passes through DRAIN, which sees an empty pipe.
            state    <= bad_geom ? DRAIN : WAIT_SOF;
          end
        end
        WAIT_SOF, RUN: begin
          if (push) begin
            if (eol_bad || sof_bad) err_size <= 1'b1;
            if (last_x) begin
              x <= '0;
              y <= by + YW'(1);
            end else begin
              x <= bx + XW'(1);
              y <= by;
            end
            state <= (last_x && last_y) ? DRAIN : RUN;
          end
        end
        DRAIN: begin
          if (pipe_empty_next) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  pixel_op_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .CHANNELS  (CHANNELS)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode_q),
    .thresh    (thresh_q),
    .in_valid  (push),
    .in_ready  (pipe_ready),
    .in_data   (s_data),
    .in_sof    ((bx == '0) && (by == '0)),
    .in_eol    (last_x),
    .in_eof    (last_x && last_y),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data),
    .out_sof   (m_sof),
    .out_eol   (m_eol),
    .out_eof   (m_eof),
    .empty_next(pipe_empty_next)
  );

endmodule

// File: tb/tb_pixel_stream_proc.sv
// tb/tb_pixel_stream_proc.sv - self-checking bench for pixel_stream_proc
`timescale 1ns/1ps
module tb_pixel_stream_proc;
  import pixel_proc_pkg::*;

  localparam int DW = 8;
  localparam int PW = 24;
  localparam int XW = 11;
  localparam int YW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic [XW-1:0] cfg_width;
  logic [YW-1:0] cfg_height;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_thresh;
  logic          start, busy, done, err_size;
  logic          s_valid, s_ready, s_sof, s_eol;
  logic [PW-1:0] s_data;
  logic          m_valid, m_ready, m_sof, m_eol, m_eof;
  logic [PW-1:0] m_data;

  logic          start4, busy4, done4, err4, s_valid4, s_ready4;
  logic          m_valid4, m_sof4, m_eol4, m_eof4;
  logic [31:0]   s_data4, m_data4;

  always #5 clk = ~clk;

  pixel_stream_proc #(.DATA_WIDTH(DW), .CHANNELS(3), .MAX_WIDTH(1024), .MAX_HEIGHT(1024)) dut (
    .clk(clk), .reset(reset), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh), .start(start), .busy(busy),
    .done(done), .err_size(err_size), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  pixel_stream_proc #(.DATA_WIDTH(8), .CHANNELS(4), .MAX_WIDTH(1024), .MAX_HEIGHT(1024)) dut4 (
    .clk(clk), .reset(reset), .cfg_width(11'd1), .cfg_height(11'd1),
    .cfg_mode(2'd2), .cfg_thresh(8'd0), .start(start4), .busy(busy4),
    .done(done4), .err_size(err4), .s_valid(s_valid4), .s_ready(s_ready4),
    .s_data(s_data4), .s_sof(1'b1), .s_eol(1'b1), .m_valid(m_valid4),
    .m_ready(1'b1), .m_data(m_data4), .m_sof(m_sof4), .m_eol(m_eol4), .m_eof(m_eof4)
  );

  typedef struct packed {
    logic [PW-1:0] data;
    logic          sof;
    logic          eol;
    logic          eof;
  } beat_t;

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] thr;
    logic [PW-1:0] din;
    logic [PW-1:0] dout;
  } vec_t;

  beat_t sbq[$];
  vec_t  vecs[8];
  int    n_checks = 0, n_pass = 0;
  int    cyc = 0, out_cnt = 0, done_cnt = 0;
  int    first_out_cyc, last_out_cyc, done_cyc, acc_cyc, start_cyc;
  int    occ = 0, stall_bad = 0;
  bit    first_acc, bp_en = 0;
  string cur_name = "frame";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output scoreboard and done timestamping.
  always @(negedge clk) begin
    beat_t e;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_valid && m_ready) begin
      if (out_cnt == 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      out_cnt++;
      if (sbq.size() == 0) check({cur_name, "_unexpected_out"}, {m_data, m_sof, m_eol, m_eof}, 64'hDEAD);
      else begin
        e = sbq.pop_front();
        check({cur_name, "_out"}, {m_data, m_sof, m_eol, m_eof}, e);
      end
    end
  end

  // A full pipe that cannot drain must stop accepting input.
  always @(negedge clk) begin
    if (reset) occ = 0;
    else begin
      if (occ == 2 && !m_ready && s_ready) stall_bad++;
      occ = occ + int'(s_valid && s_ready) - int'(m_valid && m_ready);
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_start(input int w, input int h, input logic [1:0] mode, input logic [DW-1:0] thr);
    cfg_width = XW'(w); cfg_height = YW'(h); cfg_mode = mode; cfg_thresh = thr;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [PW-1:0] d, input logic sof, input logic eol, input beat_t exp);
    int t = 0;
    bit ok = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
    do begin
      @(negedge clk);
      t++;
      ok = s_ready;
      if (!ok) begin @(posedge clk); #1; end
    end while (!ok && t < 300);
    if (!ok) check("s_ready_timeout", 0, 1);
    else begin
      if (first_acc) begin acc_cyc = cyc; first_acc = 0; end
      sbq.push_back(exp);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic wait_done(input int dc0, input int budget);
    int t = 0;
    while (done_cnt == dc0 && t < budget) begin @(posedge clk); #1; t++; end
    check({cur_name, "_done_seen"}, 64'(done_cnt != dc0), 1);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int w, input int h, input logic [1:0] mode, input int eol_bad_x, input bit bp);
    beat_t         e;
    logic [PW-1:0] d;
    int            dc0;
    bp_en = bp; out_cnt = 0; first_acc = 1; dc0 = done_cnt;
    do_start(w, h, mode, 8'd0);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        d      = PW'($urandom);
        e.data = (mode == INVERT) ? ~d : d;
        e.sof  = (xx == 0) && (yy == 0);
        e.eol  = (xx == w - 1);
        e.eof  = (xx == w - 1) && (yy == h - 1);
        send(d, e.sof, (xx == w - 1) != (xx == eol_bad_x), e);
      end
    end
    wait_done(dc0, 2000);
    bp_en = 0;
  endtask

  initial begin
    int dc0, t;
    vecs[0] = '{GRAY,   8'd0,   24'h0000FF, 24'h4C4C4C};
    vecs[1] = '{GRAY,   8'd0,   24'hFFFFFF, 24'hFFFFFF};
    vecs[2] = '{GRAY,   8'd0,   24'h00FF00, 24'h959595};
    vecs[3] = '{GRAY,   8'd0,   24'hFF0000, 24'h1C1C1C};
    vecs[4] = '{THRESH, 8'd128, 24'h7F7F7F, 24'h000000};
    vecs[5] = '{THRESH, 8'd128, 24'h808080, 24'hFFFFFF};
    vecs[6] = '{INVERT, 8'd0,   24'h102030, 24'hEFDFCF};
    vecs[7] = '{PASS,   8'd0,   24'h123456, 24'h123456};

    reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0;
    cfg_width = '0; cfg_height = '0; cfg_mode = '0; cfg_thresh = '0;
    start4 = 1'b0; s_valid4 = 1'b0; s_data4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err_size, 0);
    check("reset_s_ready", s_ready, 0);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_bus", {m_data, m_sof, m_eol, m_eof}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    cur_name = "pass4x2";
    run_frame(4, 2, PASS, -1, 0);
    check("pass_count", out_cnt, 8);
    check("pass_latency", first_out_cyc - acc_cyc, 2);
    check("pass_done_after_last", done_cyc - last_out_cyc, 1);
    check("pass_err", err_size, 0);
    check("pass_sb_empty", sbq.size(), 0);

    cur_name = "vector";
    for (int i = 0; i < 8; i++) begin
      beat_t e;
      dc0 = done_cnt;
      do_start(1, 1, vecs[i].mode, vecs[i].thr);
      e = '{vecs[i].dout, 1'b1, 1'b1, 1'b1};
      send(vecs[i].din, 1'b1, 1'b1, e);
      wait_done(dc0, 50);
    end

    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; s_valid4 = 1'b1; s_data4 = 32'h5A0000FF;
    t = 0;
    do begin @(negedge clk); t++; if (!s_ready4) begin @(posedge clk); #1; end end
    while (!s_ready4 && t < 50);
    @(posedge clk); #1;
    s_valid4 = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; if (!m_valid4) begin @(posedge clk); #1; end end
    while (!m_valid4 && t < 50);
    check("gray_alpha_4ch", m_data4, 32'h5A4C4C4C);
    @(posedge clk); #1;

    cur_name = "backpressure";
    run_frame(16, 4, INVERT, -1, 1);
    check("bp_count", out_cnt, 64);
    check("bp_stall_ready", stall_bad, 0);
    check("bp_sb_empty", sbq.size(), 0);

    cur_name = "early_eol";
    run_frame(4, 2, PASS, 2, 0);
    check("eol_err", err_size, 1);
    check("eol_count", out_cnt, 8);

    cur_name = "clean2x2";
    run_frame(2, 2, INVERT, -1, 0);
    check("clean_err_cleared", err_size, 0);

    cur_name = "midreset";
    dc0 = done_cnt;
    first_acc = 1;
    do_start(4, 2, PASS, 8'd0);
    for (int i = 0; i < 3; i++) begin
      beat_t e;
      logic [PW-1:0] d;
      d = PW'($urandom);
      e = '{d, (i == 0), 1'b0, 1'b0};
      send(d, (i == 0), 1'b0, e);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    sbq.delete();
    @(negedge clk);
    check("midreset_outputs", {busy, done, err_size, s_ready, m_valid, m_sof, m_eol, m_eof, m_data}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("midreset_no_done", done_cnt, dc0);
    cur_name = "after_reset";
    run_frame(4, 2, PASS, -1, 0);
    check("after_reset_err", err_size, 0);
    check("after_reset_count", out_cnt, 8);

    cur_name = "width0";
    dc0 = done_cnt; out_cnt = 0;
    do_start(0, 2, PASS, 8'd0);
    wait_done(dc0, 50);
    check("width0_err", err_size, 1);
    check("width0_done_cycle", done_cyc - start_cyc, 2);
    check("width0_no_output", out_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
